regtovga_bcd: RTL and testbench
===============================

Name: regtovga_bcd

Overview:
- Parametrised successor to the single-digit register-to-VGA converter.
- Converts a WIDTH-bit unsigned register value into DIGITS BCD digit codes for the VGA character renderer.
- Uses a sequential shift-and-add-3 (double-dabble) engine, one input bit per clock.
- Adds out-of-range detection (all digits forced to code 15), optional leading-zero blanking (code 14), and a valid/busy handshake toward the VGA side.

Parameters:
- WIDTH, 8, bit width of input value e (1..16)
- DIGITS, 3, number of 4-bit digit codes produced (1..5)
- BLANK, 0, 1 = replace leading zero digits with code 14 (blank glyph); the least-significant digit is never blanked

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- vgae2  input  1  VGA enable; conversions start only while high
- e  input  WIDTH  unsigned value to display
- num  output  4*DIGITS  digit codes; digit 0 (units) in num[3:0]; 0-9 digit, 14 blank, 15 exception
- valid  output  1  one-cycle pulse when num has just been updated
- busy  output  1  high while a conversion is in progress
- ovf  output  1  high when the displayed value did not fit in DIGITS digits; held with num

Behaviour:
- Reset (reset=0, async): state=IDLE, num=all 15 (exception until the first conversion), valid=0, busy=0, ovf=0, last-value register cleared, first-flag set.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Start a conversion when vgae2=1 and (first-flag or e != last-value).
  - On start: capture e into the shift register, clear the BCD register and the overflow flag, load bit counter=WIDTH, go to SHIFT.
  - busy rises the cycle after capture.
  - If vgae2=0: stay in IDLE; num/ovf hold their last values.
- SHIFT, each cycle:
  - Every BCD digit >= 5 gets +3.
  - Then {BCD, shreg} shifts left by 1.
  - The bit shifted out of the top digit sets the sticky overflow flag.
  - Decrement the counter; after WIDTH shifts, go to DONE.
- DONE (one cycle):
  - If overflow: num = all 15 and ovf=1.
  - Else: num = BCD with blanking applied, and ovf=0.
  - Blanking (BLANK=1): from the most-significant digit down, each zero digit becomes 14 until the first nonzero digit. Digit 0 is always shown.
  - valid=1 for exactly this cycle; last-value <= captured value; first-flag cleared; go to IDLE.
- Latency: capture at edge k, num/ovf/valid update at edge k+WIDTH+1. busy is high for cycles k+1 .. k+WIDTH+1 and low in IDLE.
- e and vgae2 changes during SHIFT/DONE are ignored for the current conversion. On return to IDLE, if vgae2=1 and e differs from last-value, a new conversion starts on the next edge. Back-to-back period = WIDTH+2 cycles.
- vgae2 falling mid-conversion does not abort; the result is still written.
- Reset asserted mid-conversion: immediate return to reset values; no valid pulse.
- Capture boundary: e is sampled only at the IDLE start edge. Glitches on e between conversions never appear on num unless present at a start edge.
- No combinational path from e to num.

Test Plan (WIDTH=8, DIGITS=3, BLANK=0 unless stated):
- Reset then vgae2=1, e=8'd0 -> num=12'h000, ovf=0, valid pulse exactly 9 cycles after the capture edge; before that num=12'hFFF.
- e=8'd255 -> num=12'h255, ovf=0; e held constant afterwards -> no further valid pulses.
- DIGITS=2: e=8'd99 -> num=8'h99, ovf=0; then e=8'd100 -> num=8'hFF, ovf=1.
- BLANK=1: e=8'd7 -> num=12'hEE7; e=8'd40 -> num=12'hE40; e=8'd0 -> num=12'hEE0.
- e=8'd12 captured, e changed to 8'd200 on the 3rd SHIFT cycle -> first result 12'h012, then an automatic second conversion -> 12'h200. Two valid pulses, 10 cycles apart.
- vgae2=0 with e changing -> num unchanged, busy=0; reset pulled low mid-SHIFT -> num=12'hFFF, busy=0, no valid pulse.

Source files
------------

// File: rtl/regtovga_bcd.sv
// Register-to-VGA BCD converter: sequential double-dabble
// producing DIGITS digit codes with overflow and blanking.
module regtovga_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter bit BLANK  = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vgae2,
  input  logic [WIDTH-1:0]    e,
  output logic [4*DIGITS-1:0] num,
  output logic                valid,
  output logic                busy,
  output logic                ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] last;
  logic [BW-1:0]    bcd;
  logic [BW-1:0]    bcd_adj;
  logic [BW-1:0]    shown;
  logic [CW-1:0]    cnt;
  logic             first;
  logic             sticky;
  logic             start;
  logic             seen;
  logic [3:0]       d;

  always_comb begin
    bcd_adj = '0;
    shown   = '0;
    seen    = 1'b0;
    d       = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = bcd[4*i +: 4];
      bcd_adj[4*i +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
    end
    // Blank zeros above the first nonzero digit; units always shown.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = bcd[4*i +: 4];
      if (BLANK && i != 0 && !seen && d == 4'd0)
        shown[4*i +: 4] = 4'hE;
      else
        shown[4*i +: 4] = d;
      if (d != 4'd0)
        seen = 1'b1;
    end
    start   = vgae2 && (first || e != last);
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      shreg  <= '0;
      cap    <= '0;
      last   <= '0;
      bcd    <= '0;
      cnt    <= '0;
      first  <= 1'b1;
      sticky <= 1'b0;
      num    <= '1;
      valid  <= 1'b0;
      busy   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= state_n;
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shreg  <= e;
            cap    <= e;
            bcd    <= '0;
            sticky <= 1'b0;
            cnt    <= CW'(WIDTH);
            busy   <= 1'b1;
          end
        end
        SHIFT: begin
          bcd    <= {bcd_adj[BW-2:0], shreg[WIDTH-1]};
          shreg  <= shreg << 1;
          sticky <= sticky | bcd_adj[BW-1];
          cnt    <= cnt - 1'b1;
        end
        DONE: begin
          num   <= sticky ? '1 : shown;
          ovf   <= sticky;
          valid <= 1'b1;
          busy  <= 1'b0;
          last  <= cap;
          first <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regtovga_bcd.sv
// Bench for regtovga_bcd: three parameter sets share one
// stimulus stream and are compared against a decimal model.
module tb_regtovga_bcd;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        vgae2 = 1'b0;
  logic [7:0]  e     = 8'd0;
  logic [11:0] num0;
  logic [7:0]  num1;
  logic [11:0] num2;
  logic        valid0, busy0, ovf0;
  logic        valid1, busy1, ovf1;
  logic        valid2, busy2, ovf2;

  int vectors = 0;
  int errs    = 0;
  bit run     = 1'b0;

  regtovga_bcd #(.WIDTH(8), .DIGITS(3), .BLANK(1'b0)) u0 (
    .clk(clk), .reset(reset), .vgae2(vgae2), .e(e),
    .num(num0), .valid(valid0), .busy(busy0), .ovf(ovf0)
  );
  regtovga_bcd #(.WIDTH(8), .DIGITS(2), .BLANK(1'b0)) u1 (
    .clk(clk), .reset(reset), .vgae2(vgae2), .e(e),
    .num(num1), .valid(valid1), .busy(busy1), .ovf(ovf1)
  );
  regtovga_bcd #(.WIDTH(8), .DIGITS(3), .BLANK(1'b1)) u2 (
    .clk(clk), .reset(reset), .vgae2(vgae2), .e(e),
    .num(num2), .valid(valid2), .busy(busy2), .ovf(ovf2)
  );

  always #5 clk = ~clk;

  int dig[3] = '{3, 2, 3};
  int blk[3] = '{0, 0, 1};

  function automatic int pow10(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [19:0] exp_num(
    input int val, input int digits, input int blank);
    logic [19:0] r;
    bit seen;
    int dv;
    r    = '1;
    seen = 1'b0;
    if (val >= pow10(digits)) return r;
    for (int i = digits - 1; i >= 0; i--) begin
      dv = (val / pow10(i)) % 10;
      if (blank != 0 && i > 0 && !seen && dv == 0)
        r[4*i +: 4] = 4'hE;
      else
        r[4*i +: 4] = 4'(dv);
      if (dv != 0) seen = 1'b1;
    end
    return r;
  endfunction

  // Conversion-level model: a capture starts a WIDTH+1 cycle job.
  int          m_cnt   = 0;
  bit          m_first = 1'b1;
  logic [7:0]  m_last  = 8'd0;
  logic [7:0]  m_cap   = 8'd0;
  logic [19:0] m_num[3] = '{20'hFFFFF, 20'hFFFFF, 20'hFFFFF};
  bit          m_ovf[3] = '{1'b0, 1'b0, 1'b0};
  bit          m_valid = 1'b0;
  bit          m_busy  = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt   = 0;
      m_first = 1'b1;
      m_last  = 8'd0;
      m_valid = 1'b0;
      m_busy  = 1'b0;
      for (int k = 0; k < 3; k++) begin
        m_num[k] = 20'hFFFFF;
        m_ovf[k] = 1'b0;
      end
    end else begin
      m_valid = 1'b0;
      if (m_cnt == 0) begin
        if (vgae2 && (m_first || e != m_last)) begin
          m_cap  = e;
          m_cnt  = 9;
          m_busy = 1'b1;
        end
      end else begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_valid = 1'b1;
          m_busy  = 1'b0;
          m_last  = m_cap;
          m_first = 1'b0;
          for (int k = 0; k < 3; k++) begin
            m_num[k] = exp_num(int'(m_cap), dig[k], blk[k]);
            m_ovf[k] = int'(m_cap) >= pow10(dig[k]);
          end
        end
      end
    end
  end

  task automatic check(input string name,
                       input logic [19:0] act,
                       input logic [19:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      check("num0", 20'(num0), 20'(m_num[0][11:0]));
      check("num1", 20'(num1), 20'(m_num[1][7:0]));
      check("num2", 20'(num2), 20'(m_num[2][11:0]));
      check("ovf0", 20'(ovf0), 20'(m_ovf[0]));
      check("ovf1", 20'(ovf1), 20'(m_ovf[1]));
      check("ovf2", 20'(ovf2), 20'(m_ovf[2]));
      check("valid0", 20'(valid0), 20'(m_valid));
      check("valid1", 20'(valid1), 20'(m_valid));
      check("valid2", 20'(valid2), 20'(m_valid));
      check("busy0", 20'(busy0), 20'(m_busy));
      check("busy1", 20'(busy1), 20'(m_busy));
      check("busy2", 20'(busy2), 20'(m_busy));
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!valid0 && n < 40);
    check("valid_timeout", 20'(valid0), 20'd1);
  endtask

  task automatic run_dir(input logic [7:0] v,
                         input logic [11:0] x0,
                         input logic [7:0] x1,
                         input logic x1o,
                         input logic [11:0] x2);
    int n;
    e = v;
    wait_valid(n);
    check("lit_num0", 20'(num0), 20'(x0));
    check("lit_num1", 20'(num1), 20'(x1));
    check("lit_ovf1", 20'(ovf1), 20'(x1o));
    check("lit_num2", 20'(num2), 20'(x2));
  endtask

  initial begin
    int n;
    int cnt;
    #3 reset = 1'b0;
    repeat (3) tick();
    run = 1'b1;
    check("rst_num0", 20'(num0), 20'hFFF);
    check("rst_busy0", 20'(busy0), 20'd0);
    check("rst_ovf0", 20'(ovf0), 20'd0);

    // Ticks counted include the capture edge, so WIDTH+2 total.
    e     = 8'd0;
    vgae2 = 1'b1;
    reset = 1'b1;
    wait_valid(n);
    check("latency", 20'(n), 20'd10);
    check("lit_zero0", 20'(num0), 20'h000);
    check("lit_zero2", 20'(num2), 20'hEE0);

    run_dir(8'd255, 12'h255, 8'hFF, 1'b1, 12'h255);
    cnt = 0;
    repeat (30) begin
      tick();
      if (valid0) cnt++;
    end
    check("hold_no_valid", 20'(cnt), 20'd0);

    run_dir(8'd99,  12'h099, 8'h99, 1'b0, 12'hE99);
    run_dir(8'd100, 12'h100, 8'hFF, 1'b1, 12'h100);
    run_dir(8'd7,   12'h007, 8'h07, 1'b0, 12'hEE7);
    run_dir(8'd40,  12'h040, 8'h40, 1'b0, 12'hE40);

    e = 8'd12;
    repeat (3) tick();
    e = 8'd200;
    wait_valid(n);
    check("mid_first", 20'(num0), 20'h012);
    wait_valid(n);
    check("mid_gap", 20'(n), 20'd10);
    check("mid_second", 20'(num0), 20'h200);

    vgae2 = 1'b0;
    repeat (12) begin
      e = 8'($urandom);
      tick();
      check("off_busy", 20'(busy0), 20'd0);
      check("off_num", 20'(num0), 20'h200);
    end

    e     = 8'd77;
    vgae2 = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("arst_num0", 20'(num0), 20'hFFF);
    check("arst_busy0", 20'(busy0), 20'd0);
    cnt = 0;
    repeat (12) begin
      tick();
      if (valid0) cnt++;
    end
    check("arst_no_valid", 20'(cnt), 20'd0);
    reset = 1'b1;

    repeat (1500) begin
      tick();
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 149) == 0) reset = 1'b0;
      vgae2 = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 7))
        0: e = 8'($urandom);
        1: e = 8'd99;
        2: e = 8'd100;
        3: e = 8'd255;
        4: e = 8'd0;
        default: ;
      endcase
    end

    tick();
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
